// File: rtl/object_mover_pkg.sv
// Shared definitions for the sprite mover: screen geometry defaults, velocity width, FSM state encoding.
package object_mover_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int VEL_W        = 4;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ERASE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_DRAW  = 3'd4
    } state_t;

endpackage

// File: rtl/object_mover_coord_wrap_add.sv
// Combinational coordinate step: coord + signed velocity, wrapped once into 0..LIMIT-1.
module coord_wrap_add
    import object_mover_pkg::*;
#(
    parameter int W     = 8,
    parameter int LIMIT = 160
) (
    input  logic [W-1:0]     coord,
    input  logic [VEL_W-1:0] vel,
    output logic [W-1:0]     result
);

    localparam logic signed [W+1:0] LIM = (W+2)'(LIMIT);

    logic signed [W+1:0] sum;

    // Two guard bits hold both the negative and the >= LIMIT overshoot; |vel| < LIMIT so one correction is enough.
    always_comb begin
        sum = $signed({2'b00, coord}) + $signed({{(W+2-VEL_W){vel[VEL_W-1]}}, vel});
        if (sum[W+1]) begin
            result = W'(sum + LIM);
        end else if (sum >= LIM) begin
            result = W'(sum - LIM);
        end else begin
            result = sum[W-1:0];
        end
    end

endmodule

// File: rtl/object_mover.sv
// Moves one sprite per accepted tick: erase at old position, step with wrap, redraw via draw-engine req/ack.
// Optional macro OBJECT_MOVER_OVERRUN_EN adds overrun_cnt, a saturating count of ticks dropped while busy.
module object_mover
    import object_mover_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             enable,
    input  logic [VEL_W-1:0] vel_x,
    input  logic [VEL_W-1:0] vel_y,
    output logic             draw_req,
    output logic             draw_erase,
    output logic [X_W-1:0]   draw_x,
    output logic [Y_W-1:0]   draw_y,
    input  logic             draw_ack,
    output logic [X_W-1:0]   pos_x,
    output logic [Y_W-1:0]   pos_y,
`ifdef OBJECT_MOVER_OVERRUN_EN
    output logic [7:0]       overrun_cnt,
`endif
    output logic             busy
);

    state_t         state;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;

    coord_wrap_add #(.W(X_W), .LIMIT(SCREEN_W)) u_wrap_x (
        .coord  (pos_x),
        .vel    (vel_x),
        .result (next_x)
    );

    coord_wrap_add #(.W(Y_W), .LIMIT(SCREEN_H)) u_wrap_y (
        .coord  (pos_y),
        .vel    (vel_y),
        .result (next_y)
    );

    // Request fields are only loaded on entry to ERASE/DRAW, so they stay frozen while draw_req is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            pos_x      <= X_W'(X_INIT);
            pos_y      <= Y_W'(Y_INIT);
            draw_req   <= 1'b0;
            draw_erase <= 1'b0;
            draw_x     <= X_W'(X_INIT);
            draw_y     <= Y_W'(Y_INIT);
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    state      <= ST_DRAW;
                    draw_req   <= 1'b1;
                    draw_erase <= 1'b0;
                    draw_x     <= pos_x;
                    draw_y     <= pos_y;
                end
                ST_IDLE: begin
                    if (tick && enable) begin
                        state      <= ST_ERASE;
                        draw_req   <= 1'b1;
                        draw_erase <= 1'b1;
                        draw_x     <= pos_x;
                        draw_y     <= pos_y;
                        busy       <= 1'b1;
                    end
                end
                ST_ERASE: begin
                    if (draw_ack) begin
                        state    <= ST_MOVE;
                        draw_req <= 1'b0;
                    end
                end
                ST_MOVE: begin
                    state      <= ST_DRAW;
                    pos_x      <= next_x;
                    pos_y      <= next_y;
                    draw_req   <= 1'b1;
                    draw_erase <= 1'b0;
                    draw_x     <= next_x;
                    draw_y     <= next_y;
                end
                ST_DRAW: begin
                    if (draw_ack) begin
                        state    <= ST_IDLE;
                        draw_req <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    draw_req <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

`ifdef OBJECT_MOVER_OVERRUN_EN
    // Any tick outside IDLE is a drop regardless of enable; an accepted tick starts a fresh count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= 8'd0;
        end else if (state == ST_IDLE) begin
            if (tick && enable) begin
                overrun_cnt <= 8'd0;
            end
        end else if (tick && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
